maze_wall_probe: RTL and testbench



---
 rtl/maze_wall_probe.sv | 133 +++++++++++++
 tb/tb_maze_wall_probe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/maze_wall_probe.sv
// maze_wall_probe: samples the four neighbour wall bits of one ghost tile
// per frame tick through a single ROM read port and publishes them together.
module maze_wall_probe #(
  parameter int MAZE_W   = 28,
  parameter int MAZE_H   = 36,
  parameter int TUNNEL_Y = 17,
  parameter int ROM_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [5:0] tileX,
  input  logic [5:0] tileY,
  output logic       rom_rd_en,
  output logic [9:0] rom_addr,
  input  logic       rom_data,
  output logic       wallUp,
  output logic       wallDown,
  output logic       wallLeft,
  output logic       wallRight,
  output logic       walls_valid,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic       vld;
    logic       forced;
    logic [1:0] slot;
  } tag_t;

  localparam logic signed [6:0] W7 = 7'(MAZE_W);
  localparam logic signed [6:0] H7 = 7'(MAZE_H);
  localparam logic [5:0] TUN6 = 6'(TUNNEL_Y);
  localparam logic [9:0] W10 = 10'(MAZE_W);
  localparam logic [1:0] LASTD = 2'(ROM_LAT - 1);

  state_t state, stateNext;
  logic [5:0] latX, latY;
  logic [1:0] slot, drainCnt;
  logic [3:0] cap, capNext;
  logic [3:0] flags;
  tag_t pipe [ROM_LAT];

  logic signed [6:0] x7, y7, nx, ny;
  logic slotForced, oob;
  logic [9:0] addrCalc;

  // neighbour of the current slot, with tunnel wrap and edge forcing
  always_comb begin
    x7 = signed'({1'b0, latX});
    y7 = signed'({1'b0, latY});
    nx = x7;
    ny = y7;
    slotForced = 1'b0;
    oob = (x7 >= W7) || (y7 >= H7);
    unique case (slot)
      2'd0: ny = y7 - 7'sd1;
      2'd1: ny = y7 + 7'sd1;
      2'd2: nx = x7 - 7'sd1;
      2'd3: nx = x7 + 7'sd1;
    endcase
    if (ny < 7'sd0 || ny >= H7) slotForced = 1'b1;
    if (nx < 7'sd0) begin
      if (latY == TUN6) nx = W7 - 7'sd1;
      else slotForced = 1'b1;
    end else if (nx >= W7) begin
      if (latY == TUN6) nx = 7'sd0;
      else slotForced = 1'b1;
    end
    if (oob) slotForced = 1'b1;
    addrCalc = 10'(ny) * W10 + 10'(nx);
  end

  assign rom_rd_en = (state == ISSUE) && !slotForced;
  assign rom_addr = rom_rd_en ? addrCalc : 10'd0;
  assign busy = (state == ISSUE) || (state == DRAIN);
  assign walls_valid = (state == DONE);
  assign {wallUp, wallDown, wallLeft, wallRight} = flags;

  always_comb begin
    capNext = cap;
    if (pipe[ROM_LAT-1].vld)
      capNext[pipe[ROM_LAT-1].slot] =
        pipe[ROM_LAT-1].forced ? 1'b1 : rom_data;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (frame_tick) stateNext = ISSUE;
      ISSUE: if (slot == 2'd3) stateNext = DRAIN;
      DRAIN: if (drainCnt == LASTD) stateNext = DONE;
      DONE:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      latX     <= '0;
      latY     <= '0;
      slot     <= '0;
      drainCnt <= '0;
      cap      <= 4'hF;
      flags    <= 4'hF;
      overrun  <= 1'b0;
      for (int k = 0; k < ROM_LAT; k++) pipe[k] <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && frame_tick) begin
        latX <= tileX;
        latY <= tileY;
      end
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      slot <= (state == ISSUE) ? slot + 2'd1 : 2'd0;
      drainCnt <= (state == DRAIN) ? drainCnt + 2'd1 : 2'd0;
      pipe[0].vld    <= (state == ISSUE);
      pipe[0].forced <= slotForced;
      pipe[0].slot   <= slot;
      for (int k = 1; k < ROM_LAT; k++) pipe[k] <= pipe[k-1];
      cap <= capNext;
      // flags switch on the DONE edge so they arrive with walls_valid
      if (state == DRAIN && drainCnt == LASTD)
        flags <= {capNext[0], capNext[1], capNext[2], capNext[3]};
    end
  end

endmodule

// File: tb/tb_maze_wall_probe.sv
// tb_maze_wall_probe: directed probes against two instances
// (ROM latency 1 and 3) with behavioural wall ROMs.
module tb_maze_wall_probe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic [5:0] tileX = '0, tileY = '0;

  logic rdEn1, rdEn3;
  logic [9:0] addr1, addr3;
  logic data1, data3;
  logic wU1, wD1, wL1, wR1, v1, b1, o1;
  logic wU3, wD3, wL3, wR3, v3, b3, o3;

  maze_wall_probe #(.ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .tileX(tileX), .tileY(tileY),
    .rom_rd_en(rdEn1), .rom_addr(addr1), .rom_data(data1),
    .wallUp(wU1), .wallDown(wD1), .wallLeft(wL1), .wallRight(wR1),
    .walls_valid(v1), .busy(b1), .overrun(o1)
  );

  maze_wall_probe #(.ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .tileX(tileX), .tileY(tileY),
    .rom_rd_en(rdEn3), .rom_addr(addr3), .rom_data(data3),
    .wallUp(wU3), .wallDown(wD3), .wallLeft(wL3), .wallRight(wR3),
    .walls_valid(v3), .busy(b3), .overrun(o3)
  );

  logic mem [0:1023];
  logic d1 = 1'b0;
  logic [2:0] d3 = '0;
  always @(posedge clk) begin
    d1 <= rdEn1 ? mem[addr1] : 1'b0;
    d3 <= {d3[1:0], rdEn3 ? mem[addr3] : 1'b0};
  end
  assign data1 = d1;
  assign data3 = d3[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [12:0] rdM, vM, bM, v3M;
  logic [9:0] adT [1:12];
  logic [3:0] fT [1:12];
  logic [3:0] f3T [1:12];

  task automatic clearMem();
    for (int a = 0; a < 1024; a++) mem[a] = 1'b0;
  endtask

  // tick at cycle T, then trace cycles T+1..T+12; t2/t3 add extra
  // ticks and rc asserts reset in that cycle
  task automatic run(input logic [5:0] x, input logic [5:0] y,
                     input int t2, input int t3, input int rc);
    @(negedge clk);
    tileX = x;
    tileY = y;
    frame_tick = 1'b1;
    rdM = '0; vM = '0; bM = '0; v3M = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      rdM[i] = rdEn1;
      vM[i] = v1;
      bM[i] = b1;
      v3M[i] = v3;
      adT[i] = addr1;
      fT[i] = {wU1, wD1, wL1, wR1};
      f3T[i] = {wU3, wD3, wL3, wR3};
      frame_tick = (i == t2) || (i == t3);
      rst = (i == rc);
      tileX = 6'(i * 3);
      tileY = 6'(i);
    end
    frame_tick = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    logic sawRd;
    clearMem();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sawRd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sawRd = sawRd | rdEn1 | rdEn3;
    end
    chk("rst flags", {wU1, wD1, wL1, wR1}, 4'hF);
    chk("rst flags3", {wU3, wD3, wL3, wR3}, 4'hF);
    chk("rst valid", v1, 0);
    chk("rst busy", b1, 0);
    chk("rst overrun", o1, 0);
    chk("rst addr", addr1, 0);
    chk("idle no read", sawRd, 0);

    mem[489] = 1'b1;
    mem[518] = 1'b1;
    run(13, 18, -1, -1, -1);
    chk("mid addr up", adT[1], 489);
    chk("mid addr dn", adT[2], 545);
    chk("mid addr lt", adT[3], 516);
    chk("mid addr rt", adT[4], 518);
    chk("mid rd mask", rdM, 13'h1E);
    chk("mid valid", vM, 13'h40);
    chk("mid busy", bM, 13'h3E);
    chk("mid old flags", fT[5], 4'hF);
    chk("mid flags", fT[6], 4'b1001);
    chk("mid valid3", v3M, 13'h100);
    chk("mid flags3", f3T[8], 4'b1001);
    chk("mid no ovr", o1, 0);

    clearMem();
    run(0, 17, -1, -1, -1);
    chk("tun0 up", adT[1], 448);
    chk("tun0 dn", adT[2], 504);
    chk("tun0 lt", adT[3], 503);
    chk("tun0 rt", adT[4], 477);
    chk("tun0 flags", fT[6], 4'h0);

    mem[502] = 1'b1;
    run(27, 17, -1, -1, -1);
    chk("tun27 lt", adT[3], 502);
    chk("tun27 rt", adT[4], 476);
    chk("tun27 rd", rdM, 13'h1E);
    chk("tun27 flags", fT[6], 4'b0010);
    chk("tun27 hold", fT[12], 4'b0010);
    mem[502] = 1'b0;

    run(5, 0, -1, -1, -1);
    chk("top rd mask", rdM, 13'h1C);
    chk("top dn addr", adT[2], 33);
    chk("top flags", fT[6], 4'b1000);

    run(27, 35, -1, -1, -1);
    chk("corner rd mask", rdM, 13'h0A);
    chk("corner up", adT[1], 979);
    chk("corner lt", adT[3], 1006);
    chk("corner flags", fT[6], 4'b0101);

    run(40, 3, -1, -1, -1);
    chk("oob rd mask", rdM, 0);
    chk("oob valid", vM, 13'h40);
    chk("oob busy", bM, 13'h3E);
    chk("oob flags", fT[6], 4'hF);

    mem[489] = 1'b1;
    mem[518] = 1'b1;
    chk("pre ovr", o1, 0);
    run(13, 18, 3, 6, -1);
    chk("ovr valid", vM, 13'h40);
    chk("ovr rd mask", rdM, 13'h1E);
    chk("ovr addr up", adT[1], 489);
    chk("ovr addr rt", adT[4], 518);
    chk("ovr flags", fT[6], 4'b1001);
    chk("ovr sticky", o1, 1);
    chk("ovr valid3", v3M, 13'h100);
    chk("ovr sticky3", o3, 1);

    run(5, 0, -1, -1, 4);
    chk("abort valid", vM, 0);
    chk("abort valid3", v3M, 0);
    chk("abort busy", bM, 13'h1E);
    chk("abort flags", fT[6], 4'hF);
    chk("abort ovr clr", o1, 0);

    run(13, 18, -1, -1, -1);
    chk("again valid", vM, 13'h40);
    chk("again addr", adT[1], 489);
    chk("again flags", fT[6], 4'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
